scc_mem_arbiter: RTL and testbench
==================================

// Module: scc_mem_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between three requesters: SCC fetch (IF), SCC
//  load/store (DM) and the program loader (LD). Sits between the SCC core and Instruction_and_data.
//  Grants at most one access per cycle and routes read data back to the owner after a fixed latency.
//  Blocks fetch starvation with an aging counter.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width, all ports
//  RD_LAT      1   memory read latency in cycles, from mem_en to mem_rdata valid (>=1)
//  STARVE_MAX  4   consecutive denied IF cycles before IF outranks DM (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  if_req     in   1       fetch read request, held with if_addr stable until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       fetch accepted this cycle
//  if_rvalid  out  1       fetch data valid, exactly RD_LAT cycles after if_gnt
//  if_rdata   out  DATA_W  fetch data
//  dm_req     in   1       data request, held with dm_we/dm_addr/dm_wdata stable until dm_gnt
//  dm_we      in   1       1 = write, 0 = read
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  store data
//  dm_gnt     out  1       data access accepted this cycle
//  dm_rvalid  out  1       load data valid (reads only), RD_LAT cycles after dm_gnt
//  dm_rdata   out  DATA_W  load data
//  ld_req     in   1       loader write request, held until ld_gnt
//  ld_addr    in   ADDR_W  loader address
//  ld_wdata   in   DATA_W  loader data
//  ld_gnt     out  1       loader write accepted this cycle
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable, valid with mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
// BEHAVIOUR
//  - Grant is combinational from the req inputs and the registered starve_cnt. Same-cycle mem_* drive from the winner.
//  - Priority: LD > DM > IF. If starve_cnt == STARVE_MAX, IF beats DM. LD still wins.
//  - Exactly one gnt is high when any req is high; mem_en = OR of gnts; mem_we = ld_gnt | (dm_gnt & dm_we).
//  - No winner: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
//  - starve_cnt (0..STARVE_MAX, saturating) counts per edge:
//      if_req & !if_gnt -> +1. if_gnt or !if_req -> 0.
//  - Response tag pipe: RD_LAT-deep shift of owner {NONE, IF, DM}. A read grant pushes its owner, otherwise NONE.
//    Tag output = IF -> if_rvalid=1. Tag output = DM -> dm_rvalid=1. rvalid for one cycle per read.
//  - if_rdata = dm_rdata = mem_rdata (unqualified). Consumers sample only on rvalid.
//  - Back-to-back reads on every cycle are legal. Responses return in grant order, never merged or dropped.
//  - Reset (async): tag pipe = NONE and starve_cnt = 0. While reset is high, all gnt and rvalid = 0 and mem_en/mem_we = 0.
//  - Reset mid-flight: pending responses are discarded. No rvalid for grants made before the reset.
//  - Dropping req before gnt is illegal (not checked). Changing the request after gnt is legal.
// STRUCTURE
//  - scc_mem_pkg: owner_t enum {OWN_NONE, OWN_IF, OWN_DM}, ADDR_W/DATA_W defaults.
//  - Sub-module scc_rsp_tag_pipe: RD_LAT-stage owner_t shift register with async reset.
//  - Top: priority/aging grant logic, starve counter, memory mux, rvalid decode.
// TESTING
//  1 Reset held: reqs all 1 -> all gnt=0, mem_en=0, rvalid=0. Release -> LD granted on the first cycle.
//  2 IF-only read 0x100, RD_LAT=1 -> if_gnt cycle N, mem_addr=0x100, mem_we=0. if_rvalid=1 at N+1 with mem_rdata.
//  3 IF+DM req every cycle, STARVE_MAX=4 -> DM wins 4 cycles, IF wins 5th, counter 0, pattern repeats.
//  4 DM write 0x200<=0xDEADBEEF, then DM read 0x200 -> mem_we 1 then 0. dm_rvalid only after read, data 0xDEADBEEF.
//  5 RD_LAT=3, reads alternate IF/DM on 4 consecutive cycles -> rvalids at +3 in order IF,DM,IF,DM with no overlap.
//  6 DM read granted, reset pulsed next cycle -> no dm_rvalid after reset. starve_cnt back to 0.

Source files
------------

// File: rtl/scc_mem_pkg.sv
// Shared types and default widths for the SCC memory arbiter slice.
package scc_mem_pkg;

  // Owner of an in-flight read response.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int unsigned SCC_ADDR_W = 32;
  localparam int unsigned SCC_DATA_W = 32;

endpackage

// File: rtl/scc_rsp_tag_pipe.sv
// RD_LAT-deep shift register of response owners; its output marks which
// requester the current mem_rdata belongs to.
module scc_rsp_tag_pipe
  import scc_mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t stage [RD_LAT];

  // Shift owner tags one stage per cycle; reset discards pending responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stage[i] <= OWN_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/scc_mem_arbiter.sv
// Shares one single-ported memory between fetch (IF), load/store (DM) and
// the program loader (LD). Fixed priority LD > DM > IF, with an aging
// counter that lets a starved fetch outrank DM.
module scc_mem_arbiter
  import scc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = SCC_ADDR_W,
  parameter int unsigned DATA_W     = SCC_DATA_W,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             if_starved;
  owner_t           tag_in;
  owner_t           tag_out;

  assign if_starved = (starve_cnt == CNT_MAX);

  // Grant arbitration; everything is held off while reset is asserted.
  always_comb begin
    ld_gnt = 1'b0;
    dm_gnt = 1'b0;
    if_gnt = 1'b0;
    if (!reset) begin
      if (ld_req) begin
        ld_gnt = 1'b1;
      end else if (if_req && (if_starved || !dm_req)) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  // Memory port driven from the winner; idle cycles drive zeros.
  always_comb begin
    mem_en    = ld_gnt | dm_gnt | if_gnt;
    mem_we    = ld_gnt | (dm_gnt & dm_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Aging counter: counts consecutive denied fetch cycles, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (!if_starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Owner tag of the current read grant; writes and idle cycles push NONE.
  always_comb begin
    tag_in = OWN_NONE;
    if (if_gnt) begin
      tag_in = OWN_IF;
    end else if (dm_gnt && !dm_we) begin
      tag_in = OWN_DM;
    end
  end

  scc_rsp_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign if_rvalid = (tag_out == OWN_IF);
  assign dm_rvalid = (tag_out == OWN_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Bench for scc_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share
// stimulus; each has its own memory model and response scoreboard.
module tb_scc_mem_arbiter;

  typedef struct {
    int          own;   // 1 = IF, 2 = DM
    logic [31:0] data;
    int          due;
  } sb_t;

  logic        clk, reset;
  logic        if_req, dm_req, dm_we, ld_req;
  logic [31:0] if_addr, dm_addr, dm_wdata, ld_addr, ld_wdata;
  logic [31:0] rd1, rd3;
  logic [31:0] p3 [3];

  logic        u1_if_gnt, u1_if_rvalid, u1_dm_gnt, u1_dm_rvalid, u1_ld_gnt, u1_mem_en, u1_mem_we;
  logic [31:0] u1_if_rdata, u1_dm_rdata, u1_mem_addr, u1_mem_wdata;
  logic        u3_if_gnt, u3_if_rvalid, u3_dm_gnt, u3_dm_rvalid, u3_ld_gnt, u3_mem_en, u3_mem_we;
  logic [31:0] u3_if_rdata, u3_dm_rdata, u3_mem_addr, u3_mem_wdata;
  logic [4:0]  s1, s3;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  sb_t         q1[$];
  sb_t         q3[$];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];

  scc_mem_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(u1_if_gnt), .if_rvalid(u1_if_rvalid), .if_rdata(u1_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(u1_dm_gnt), .dm_rvalid(u1_dm_rvalid), .dm_rdata(u1_dm_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(u1_ld_gnt),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
    .mem_rdata(rd1)
  );

  scc_mem_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(u3_if_gnt), .if_rvalid(u3_if_rvalid), .if_rdata(u3_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(u3_dm_gnt), .dm_rvalid(u3_dm_rvalid), .dm_rdata(u3_dm_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(u3_ld_gnt),
    .mem_en(u3_mem_en), .mem_we(u3_mem_we), .mem_addr(u3_mem_addr), .mem_wdata(u3_mem_wdata),
    .mem_rdata(rd3)
  );

  assign s1 = {u1_ld_gnt, u1_dm_gnt, u1_if_gnt, u1_mem_en, u1_mem_we};
  assign s3 = {u3_ld_gnt, u3_dm_gnt, u3_if_gnt, u3_mem_en, u3_mem_we};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
  endfunction

  // Memory models: latency-1 and latency-3 read pipes, one shared array.
  always @(posedge clk) begin
    rd1   <= (u1_mem_en && !u1_mem_we) ? mem_rd(u1_mem_addr) : 32'hBAD0_0001;
    p3[0] <= (u3_mem_en && !u3_mem_we) ? mem_rd(u3_mem_addr) : 32'hBAD0_0003;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (u1_mem_en && u1_mem_we) mem_arr[u1_mem_addr] = u1_mem_wdata;
  end
  assign rd3 = p3[2];

  // Response monitor for the RD_LAT=1 instance.
  always @(negedge clk) begin : mon1
    sb_t e;
    int          go;
    logic [31:0] gd;
    if (u1_if_rvalid && u1_dm_rvalid) begin
      n_cmp++; n_err++;
      $display("FAIL lat1_overlap both rvalid at cyc %0d", cyc);
    end
    if (u1_if_rvalid || u1_dm_rvalid) begin
      n_cmp++;
      go = u1_if_rvalid ? 1 : 2;
      gd = u1_if_rvalid ? u1_if_rdata : u1_dm_rdata;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL lat1_rsp unexpected owner=%0d at cyc %0d, required none", go, cyc);
      end else begin
        e = q1.pop_front();
        if (go !== e.own || gd !== e.data || cyc !== e.due) begin
          n_err++;
          $display("FAIL lat1_rsp got own=%0d data=%h cyc=%0d, required own=%0d data=%h cyc=%0d",
                   go, gd, cyc, e.own, e.data, e.due);
        end
      end
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      n_cmp++; n_err++;
      $display("FAIL lat1_rsp missing at cyc %0d, required own=%0d due=%0d", cyc, q1[0].own, q1[0].due);
      void'(q1.pop_front());
    end
  end

  // Response monitor for the RD_LAT=3 instance.
  always @(negedge clk) begin : mon3
    sb_t e;
    int          go;
    logic [31:0] gd;
    if (u3_if_rvalid && u3_dm_rvalid) begin
      n_cmp++; n_err++;
      $display("FAIL lat3_overlap both rvalid at cyc %0d", cyc);
    end
    if (u3_if_rvalid || u3_dm_rvalid) begin
      n_cmp++;
      go = u3_if_rvalid ? 1 : 2;
      gd = u3_if_rvalid ? u3_if_rdata : u3_dm_rdata;
      if (q3.size() == 0) begin
        n_err++;
        $display("FAIL lat3_rsp unexpected owner=%0d at cyc %0d, required none", go, cyc);
      end else begin
        e = q3.pop_front();
        if (go !== e.own || gd !== e.data || cyc !== e.due) begin
          n_err++;
          $display("FAIL lat3_rsp got own=%0d data=%h cyc=%0d, required own=%0d data=%h cyc=%0d",
                   go, gd, cyc, e.own, e.data, e.due);
        end
      end
    end else if (q3.size() > 0 && q3[0].due <= cyc) begin
      n_cmp++; n_err++;
      $display("FAIL lat3_rsp missing at cyc %0d, required own=%0d due=%0d", cyc, q3[0].own, q3[0].due);
      void'(q3.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    if_req = 1'b0; dm_req = 1'b0; ld_req = 1'b0; dm_we = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_reqs();
    repeat (n) tick();
  endtask

  // Called at the negedge of a cycle in which a read grant is expected.
  task automatic push_rd(input int own, input logic [31:0] a);
    q1.push_back('{own: own, data: exp_rd(a), due: cyc + 1});
    q3.push_back('{own: own, data: exp_rd(a), due: cyc + 3});
  endtask

  task automatic test_reset();
    if_req = 1'b1; dm_req = 1'b1; ld_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h100; dm_addr = 32'h80; ld_addr = 32'h40; ld_wdata = 32'h1111_2222;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({s1, s3, u1_if_rvalid, u1_dm_rvalid, u3_if_rvalid, u3_dm_rvalid} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_held got s1=%b s3=%b, required all zero", s1, s3);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s1, s3} !== {2{5'b10011}} || u1_mem_addr !== 32'h40 || u1_mem_wdata !== 32'h1111_2222) begin
      n_err++;
      $display("FAIL reset_release got s1=%b s3=%b addr=%h wdata=%h, required 10011 addr=40 wdata=11112222",
               s1, s3, u1_mem_addr, u1_mem_wdata);
    end
    exp_mem[32'h40] = 32'h1111_2222;
    tick();
    idle(2);
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    n_cmp++;
    if ({s1, s3} !== {2{5'b00110}} || u1_mem_addr !== 32'h100 || u3_mem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL if_read got s1=%b s3=%b addr=%h, required 00110 addr=100", s1, s3, u1_mem_addr);
    end
    push_rd(1, 32'h100);
    tick();
    idle(4);
  endtask

  task automatic test_starve();
    int cnt = 0;
    logic win_if;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h300; dm_addr = 32'h400;
    for (int i = 0; i < 10; i++) begin
      win_if = (cnt == 4);
      @(negedge clk);
      n_cmp++;
      if ({s1, s3} !== {2{(win_if ? 5'b00110 : 5'b01010)}} ||
          u1_mem_addr !== (win_if ? 32'h300 : 32'h400)) begin
        n_err++;
        $display("FAIL starve_%0d got s1=%b s3=%b addr=%h, required if_win=%0d", i, s1, s3, u1_mem_addr, win_if);
      end
      push_rd(win_if ? 1 : 2, win_if ? 32'h300 : 32'h400);
      cnt = win_if ? 0 : ((cnt < 4) ? cnt + 1 : 4);
      tick();
    end
    idle(4);
  endtask

  task automatic test_dm_write_read();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if ({s1, s3} !== {2{5'b01011}} || u1_mem_addr !== 32'h200 || u1_mem_wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL dm_write got s1=%b s3=%b addr=%h wdata=%h, required 01011 addr=200 wdata=deadbeef",
               s1, s3, u1_mem_addr, u1_mem_wdata);
    end
    exp_mem[32'h200] = 32'hDEAD_BEEF;
    tick();
    dm_we = 1'b0; dm_wdata = 32'h0;
    @(negedge clk);
    n_cmp++;
    if ({s1, s3} !== {2{5'b01010}} || u1_mem_addr !== 32'h200) begin
      n_err++;
      $display("FAIL dm_read got s1=%b s3=%b addr=%h, required 01010 addr=200", s1, s3, u1_mem_addr);
    end
    push_rd(2, 32'h200);
    tick();
    idle(4);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if_req  = (i % 2 == 0);
      dm_req  = (i % 2 == 1);
      if_addr = 32'h500 + 32'(4 * i);
      dm_addr = 32'h500 + 32'(4 * i);
      @(negedge clk);
      n_cmp++;
      if ({s1, s3} !== {2{((i % 2 == 0) ? 5'b00110 : 5'b01010)}} || u3_mem_addr !== 32'h500 + 32'(4 * i)) begin
        n_err++;
        $display("FAIL b2b_%0d got s1=%b s3=%b addr=%h", i, s1, s3, u3_mem_addr);
      end
      push_rd((i % 2 == 0) ? 1 : 2, 32'h500 + 32'(4 * i));
      tick();
    end
    idle(5);
  endtask

  task automatic test_reset_midflight();
    int cnt = 0;
    logic win_if;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; if_addr = 32'h700; dm_addr = 32'h600;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({s1, s3} !== {2{5'b01010}}) begin
        n_err++;
        $display("FAIL midflight_pre_%0d got s1=%b s3=%b, required 01010", i, s1, s3);
      end
      push_rd(2, 32'h600);
      tick();
    end
    reset = 1'b1;
    q1.delete();
    q3.delete();
    @(negedge clk);
    n_cmp++;
    if ({s1, s3, u1_dm_rvalid, u3_dm_rvalid} !== 12'd0) begin
      n_err++;
      $display("FAIL midflight_reset got s1=%b s3=%b rv1=%b rv3=%b, required zeros",
               s1, s3, u1_dm_rvalid, u3_dm_rvalid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      win_if = (cnt == 4);
      @(negedge clk);
      n_cmp++;
      if ({s1, s3} !== {2{(win_if ? 5'b00110 : 5'b01010)}}) begin
        n_err++;
        $display("FAIL midflight_post_%0d got s1=%b s3=%b, required if_win=%0d", i, s1, s3, win_if);
      end
      push_rd(win_if ? 1 : 2, win_if ? 32'h700 : 32'h600);
      cnt = win_if ? 0 : cnt + 1;
      tick();
    end
    idle(5);
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    if_addr = '0; dm_addr = '0; dm_wdata = '0; ld_addr = '0; ld_wdata = '0;
    test_reset();
    test_if_read();
    test_starve();
    test_dm_write_read();
    test_back_to_back();
    test_reset_midflight();
    @(negedge clk);
    n_cmp++;
    if (q1.size() != 0 || q3.size() != 0) begin
      n_err++;
      $display("FAIL drain got pending q1=%0d q3=%0d, required 0", q1.size(), q3.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
